// File: rtl/inst_fetch_prefetch.sv
// Sequential instruction prefetcher: queues in-order fetched words and serves INST for PC in the same cycle on a head hit.
// A head miss raises inst_mem_hazard; a PC off the expected stream redirects fetch, with outstanding responses dropped as stale.
module inst_fetch_prefetch #(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int DEPTH           = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic [INST_ADDR_WIDTH-1:0] PC,
  input  logic                       fetch_accept,
  output logic [INST_WIDTH-1:0]      INST,
  output logic                       inst_mem_hazard,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]      imem_rsp_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = PW + 3;
  localparam logic [INST_WIDTH-1:0]      NOP   = INST_WIDTH'(32'h0000_0013);
  localparam logic [INST_ADDR_WIDTH-1:0] WSTEP = INST_ADDR_WIDTH'(4);

  logic [INST_ADDR_WIDTH-1:0] q_addr_q [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] q_addr_d [DEPTH];
  logic [INST_WIDTH-1:0]      q_data_q [DEPTH];
  logic [INST_WIDTH-1:0]      q_data_d [DEPTH];
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [INST_ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d, tail_addr_q, tail_addr_d;
  logic [INST_ADDR_WIDTH-1:0] expect_addr_q, expect_addr_d, pend_addr_q, pend_addr_d;
  logic                       pend_q, pend_d, stale_q, stale_d;

  logic          hit, redirect, can_issue, req_acc, stale_acc, pop, push;
  logic [SW-1:0] occupancy;

  always_comb begin
    hit             = (count_q != '0) && (q_addr_q[rd_ptr_q] == PC);
    INST            = hit ? q_data_q[rd_ptr_q] : NOP;
    inst_mem_hazard = !hit;
    redirect        = !hit && (PC != expect_addr_q);
    occupancy       = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);
    can_issue       = (occupancy < SW'(DEPTH)) && !redirect;
    // A raised request stays up until accepted, even across a redirect.
    imem_req_valid  = cpu_rst_n && (pend_q || can_issue);
    imem_req_addr   = pend_q ? pend_addr_q : fetch_addr_q;
    req_acc         = imem_req_valid && imem_req_ready;
    stale_acc       = req_acc && pend_q && (stale_q || redirect);
    pop             = hit && fetch_accept;
    push            = imem_rsp_valid && (discard_q == '0);
  end

  always_comb begin
    q_addr_d      = q_addr_q;
    q_data_d      = q_data_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_d    = inflight_q;
    discard_d     = discard_q;
    fetch_addr_d  = fetch_addr_q;
    tail_addr_d   = tail_addr_q;
    expect_addr_d = expect_addr_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    stale_d       = stale_q;

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      expect_addr_d = expect_addr_q + WSTEP;
    end
    if (imem_rsp_valid) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end else begin
        q_addr_d[wr_ptr_q] = tail_addr_q;
        q_data_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d           = wr_ptr_q + PW'(1);
        tail_addr_d        = tail_addr_q + WSTEP;
        inflight_d         = inflight_q - CW'(1);
      end
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (req_acc) begin
      pend_d  = 1'b0;
      stale_d = 1'b0;
      if (stale_acc) begin
        discard_d = discard_d + CW'(1);
      end else begin
        inflight_d   = inflight_d + CW'(1);
        fetch_addr_d = fetch_addr_q + WSTEP;
      end
    end else if (imem_req_valid) begin
      pend_d      = 1'b1;
      pend_addr_d = imem_req_addr;
      stale_d     = pend_q && (stale_q || redirect);
    end

    if (redirect) begin
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      discard_d     = discard_d + inflight_d;
      inflight_d    = '0;
      fetch_addr_d  = PC;
      tail_addr_d   = PC;
      expect_addr_d = PC;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= RESET_PC;
      tail_addr_q   <= RESET_PC;
      expect_addr_q <= RESET_PC;
      pend_q        <= 1'b0;
      pend_addr_q   <= RESET_PC;
      stale_q       <= 1'b0;
    end else begin
      q_addr_q      <= q_addr_d;
      q_data_q      <= q_data_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
      fetch_addr_q  <= fetch_addr_d;
      tail_addr_q   <= tail_addr_d;
      expect_addr_q <= expect_addr_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
      stale_q       <= stale_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_prefetch.sv
// Directed bench for inst_fetch_prefetch; memory word at address a reads as 32'hDEAD_0000 | a[15:0].
module tb_inst_fetch_prefetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic [31:0] PC;
  logic        fetch_accept;
  logic [31:0] INST;
  logic        inst_mem_hazard;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic        p0_v = 1'b0;
  logic [31:0] p0_a = '0;

  inst_fetch_prefetch dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst_n      (cpu_rst_n),
    .PC             (PC),
    .fetch_accept   (fetch_accept),
    .INST           (INST),
    .inst_mem_hazard(inst_mem_hazard),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hDEAD_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic haz, input logic [31:0] inst);
    chk({tag, "_hazard"}, {31'h0, inst_mem_hazard}, {31'h0, haz});
    chk({tag, "_inst"}, INST, inst);
  endtask

  task automatic expect_req(input string tag, input logic vld, input logic [31:0] addr);
    chk({tag, "_req_valid"}, {31'h0, imem_req_valid}, {31'h0, vld});
    if (vld) chk({tag, "_req_addr"}, imem_req_addr, addr);
  endtask

  task automatic drive(input logic [31:0] pc, input logic acc, input logic rdy);
    PC = pc;
    fetch_accept = acc;
    imem_req_ready = rdy;
    #1;
  endtask

  // Memory model: accepted request returns lat cycles later, in order.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge cpu_clk);
    #1;
    if (!cpu_rst_n) begin
      imem_rsp_valid = 1'b0;
      p0_v = 1'b0;
    end else if (lat == 1) begin
      imem_rsp_valid = acc;
      imem_rsp_data  = memf(a);
      p0_v = 1'b0;
    end else begin
      imem_rsp_valid = p0_v;
      imem_rsp_data  = memf(p0_a);
      p0_v = acc;
      p0_a = a;
    end
    @(negedge cpu_clk);
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    drive(32'h0, 1'b1, 1'b1);
    tick();
    tick();
    expect_out("rst", 1'b1, NOP);
    expect_req("rst", 1'b0, 32'h0);

    // Cold start: two hazard cycles, then one word per cycle.
    cpu_rst_n = 1'b1;
    drive(32'h0, 1'b1, 1'b1);
    expect_out("t1_c0", 1'b1, NOP);  expect_req("t1_c0", 1'b1, 32'h0);  tick();
    drive(32'h0, 1'b1, 1'b1);
    expect_out("t1_c1", 1'b1, NOP);  expect_req("t1_c1", 1'b1, 32'h4);  tick();
    drive(32'h0, 1'b1, 1'b1);
    expect_out("t1_c2", 1'b0, 32'hDEAD_0000);  tick();
    drive(32'h4, 1'b1, 1'b1);
    expect_out("t1_c3", 1'b0, 32'hDEAD_0004);  tick();

    // Core stalls on 0x8: queue fills to the cap and issue stops.
    for (int i = 0; i < 6; i++) begin
      drive(32'h8, 1'b0, 1'b1);
      expect_out($sformatf("t2_stall%0d", i), 1'b0, 32'hDEAD_0008);
      expect_req($sformatf("t2_stall%0d", i), i < 2, 32'h10 + 32'(4 * i));
      tick();
    end
    drive(32'h8, 1'b1, 1'b1);
    expect_out("t2_r0", 1'b0, 32'hDEAD_0008);  expect_req("t2_r0", 1'b0, 32'h0);  tick();
    drive(32'hC, 1'b1, 1'b1);
    expect_out("t2_r1", 1'b0, 32'hDEAD_000C);  expect_req("t2_r1", 1'b1, 32'h18); tick();
    drive(32'h10, 1'b1, 1'b1);
    expect_out("t2_r2", 1'b0, 32'hDEAD_0010);  expect_req("t2_r2", 1'b1, 32'h1C); tick();
    drive(32'h14, 1'b1, 1'b1);
    expect_out("t2_r3", 1'b0, 32'hDEAD_0014);  expect_req("t2_r3", 1'b1, 32'h20); tick();

    // Memory not ready for 4 cycles: request held, queue drains to a hazard.
    drive(32'h18, 1'b1, 1'b0);
    expect_out("t4_s0", 1'b0, 32'hDEAD_0018);  expect_req("t4_s0", 1'b1, 32'h24); tick();
    drive(32'h1C, 1'b1, 1'b0);
    expect_out("t4_s1", 1'b0, 32'hDEAD_001C);  expect_req("t4_s1", 1'b1, 32'h24); tick();
    drive(32'h20, 1'b1, 1'b0);
    expect_out("t4_s2", 1'b0, 32'hDEAD_0020);  expect_req("t4_s2", 1'b1, 32'h24); tick();
    drive(32'h24, 1'b1, 1'b0);
    expect_out("t4_s3", 1'b1, NOP);            expect_req("t4_s3", 1'b1, 32'h24); tick();
    drive(32'h24, 1'b1, 1'b1);
    expect_out("t4_acc", 1'b1, NOP);           expect_req("t4_acc", 1'b1, 32'h24); tick();
    drive(32'h24, 1'b1, 1'b1);
    expect_out("t4_rsp", 1'b1, NOP);           expect_req("t4_rsp", 1'b1, 32'h28); tick();
    drive(32'h24, 1'b1, 1'b1);
    expect_out("t4_hit", 1'b0, 32'hDEAD_0024); expect_req("t4_hit", 1'b1, 32'h2C); tick();

    // Redirect to 0x40 while the 0x30 request is held: 0x30 goes out, its data is dropped.
    drive(32'h28, 1'b1, 1'b0);
    expect_out("t5_pend", 1'b0, 32'hDEAD_0028); expect_req("t5_pend", 1'b1, 32'h30); tick();
    drive(32'h40, 1'b1, 1'b0);
    expect_out("t5_redir", 1'b1, NOP);          expect_req("t5_redir", 1'b1, 32'h30); tick();
    drive(32'h40, 1'b1, 1'b1);
    expect_out("t5_stale", 1'b1, NOP);          expect_req("t5_stale", 1'b1, 32'h30); tick();
    drive(32'h40, 1'b1, 1'b1);
    expect_out("t5_drop", 1'b1, NOP);           expect_req("t5_drop", 1'b1, 32'h40); tick();
    drive(32'h40, 1'b1, 1'b1);
    expect_out("t5_rsp", 1'b1, NOP);            expect_req("t5_rsp", 1'b1, 32'h44); tick();
    drive(32'h40, 1'b1, 1'b1);
    expect_out("t5_hit", 1'b0, 32'hDEAD_0040);  expect_req("t5_hit", 1'b1, 32'h48); tick();

    // Two-cycle memory; redirect to 0x80 with two responses outstanding.
    lat = 2;
    drive(32'h44, 1'b1, 1'b1);
    expect_out("t3_a", 1'b0, 32'hDEAD_0044);   expect_req("t3_a", 1'b1, 32'h4C); tick();
    drive(32'h48, 1'b1, 1'b1);
    expect_out("t3_b", 1'b0, 32'hDEAD_0048);   expect_req("t3_b", 1'b1, 32'h50); tick();
    drive(32'h80, 1'b1, 1'b1);
    expect_out("t3_redir", 1'b1, NOP);         expect_req("t3_redir", 1'b0, 32'h0); tick();
    drive(32'h80, 1'b1, 1'b1);
    expect_out("t3_w0", 1'b1, NOP);            expect_req("t3_w0", 1'b1, 32'h80); tick();
    drive(32'h80, 1'b1, 1'b1);
    expect_out("t3_w1", 1'b1, NOP);            expect_req("t3_w1", 1'b1, 32'h84); tick();
    drive(32'h80, 1'b1, 1'b1);
    expect_out("t3_w2", 1'b1, NOP);            expect_req("t3_w2", 1'b1, 32'h88); tick();
    drive(32'h80, 1'b1, 1'b1);
    expect_out("t3_hit", 1'b0, 32'hDEAD_0080); expect_req("t3_hit", 1'b1, 32'h8C); tick();
    drive(32'h84, 1'b1, 1'b1);
    expect_out("t3_next", 1'b0, 32'hDEAD_0084); expect_req("t3_next", 1'b1, 32'h90); tick();

    // Reset mid-stream, then restart from address 0.
    cpu_rst_n = 1'b0;
    drive(32'h88, 1'b0, 1'b1);
    tick();
    expect_out("t6_rst", 1'b1, NOP);           expect_req("t6_rst", 1'b0, 32'h0);
    cpu_rst_n = 1'b1;
    lat = 1;
    drive(32'h0, 1'b1, 1'b1);
    expect_out("t6_c0", 1'b1, NOP);            expect_req("t6_c0", 1'b1, 32'h0); tick();
    drive(32'h0, 1'b1, 1'b1);
    expect_out("t6_c1", 1'b1, NOP);            expect_req("t6_c1", 1'b1, 32'h4); tick();
    drive(32'h0, 1'b1, 1'b1);
    expect_out("t6_c2", 1'b0, 32'hDEAD_0000);  tick();
    drive(32'h4, 1'b1, 1'b1);
    expect_out("t6_c3", 1'b0, 32'hDEAD_0004);  tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
